// File: rtl/mux_n1_scan.sv
// mux_n1_scan -- registered N:1 channel multiplexer with manual and scan modes.
//
// Picks one WIDTH-bit lane out of N packed input lanes and registers it.
// In manual mode the lane comes from SEL; in scan mode the lane rotates
// round-robin, dwelling DWELL unheld cycles on each channel.
//
// Ports:
//   CLK    in   1        rising-edge clock
//   RST    in   1        synchronous active-high reset
//   SEL    in   SELW     manual channel select (out-of-range values ignored)
//   MODE   in   1        0 = manual, 1 = scan
//   HOLD   in   1        scan only: freeze channel and dwell counter
//   IN     in   N*WIDTH  packed lanes, channel k = IN[k*WIDTH +: WIDTH]
//   OUT    out  WIDTH    registered data of the selected channel
//   CH     out  SELW     registered current channel index
//   CH_CHG out  1        one-cycle pulse in the cycle after CH changed
module mux_n1_scan #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int DWELL = 3,
  localparam int SELW = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [SELW-1:0]      SEL,
  input  logic                 MODE,
  input  logic                 HOLD,
  input  logic [N*WIDTH-1:0]   IN,
  output logic [WIDTH-1:0]     OUT,
  output logic [SELW-1:0]      CH,
  output logic                 CH_CHG
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  // One extra bit so that N itself is representable for the range check.
  localparam logic [SELW:0]   NMAX     = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(N - 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [SELW-1:0] ch_nx;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    state_nx = MODE ? SCAN : MANUAL;
    cnt_nx   = cnt;
    ch_nx    = CH;
    if (!MODE) begin
      // Manual rule also covers the SCAN->MANUAL edge.
      cnt_nx = '0;
      if ({1'b0, SEL} < NMAX) begin
        ch_nx = SEL;
      end
    end else if (state == MANUAL) begin
      // Entry edge into scan: restart the dwell on the current channel
      // so the first advance lands DWELL edges later.
      cnt_nx = '0;
    end else if (!HOLD) begin
      if (cnt == LAST_CNT) begin
        cnt_nx = '0;
        ch_nx  = (CH == LAST_CH) ? '0 : CH + 1'b1;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
    sel_data = IN[ch_nx*WIDTH +: WIDTH];
  end

  // Stage boundary: channel, data and change flag registered together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= MANUAL;
      cnt    <= '0;
      CH     <= '0;
      OUT    <= '0;
      CH_CHG <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      CH     <= ch_nx;
      OUT    <= sel_data;
      CH_CHG <= (ch_nx != CH);
    end
  end

endmodule

// File: tb/tb_mux_n1_scan.sv
module tb_mux_n1_scan;

  logic        CLK;
  logic        RST;
  logic [1:0]  SEL;
  logic        MODE;
  logic        HOLD;
  logic [7:0]  lane [4];
  logic [31:0] IN;
  logic [7:0]  out4;
  logic [1:0]  ch4;
  logic        chg4;

  logic [1:0]  sel3;
  logic        mode3;
  logic [23:0] in3;
  logic [7:0]  out3;
  logic [1:0]  ch3;
  logic        chg3;

  int total = 0;
  int bad   = 0;

  assign IN  = {lane[3], lane[2], lane[1], lane[0]};
  assign in3 = 24'h332211;

  mux_n1_scan #(.N(4), .WIDTH(8), .DWELL(3)) dut4 (
    .CLK(CLK), .RST(RST), .SEL(SEL), .MODE(MODE), .HOLD(HOLD),
    .IN(IN), .OUT(out4), .CH(ch4), .CH_CHG(chg4)
  );

  mux_n1_scan #(.N(3), .WIDTH(8), .DWELL(3)) dut3 (
    .CLK(CLK), .RST(RST), .SEL(sel3), .MODE(mode3), .HOLD(1'b0),
    .IN(in3), .OUT(out3), .CH(ch3), .CH_CHG(chg3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: per instance k, the channel, the number of unheld
  // scan edges since entry / last advance, and whether the previous edge
  // was a scan edge.
  int m_ch   [2];
  int m_run  [2];
  bit m_scan [2];
  int m_out  [2];
  int m_chg  [2];
  bit m_ok   [2] = '{1'b0, 1'b0};

  task automatic model_edge(input int k, input int n, input int dw,
                            input bit rst, input bit mode, input bit hold,
                            input int sel, input logic [31:0] lanes);
    int nc;
    if (rst) begin
      m_ch[k] = 0; m_run[k] = 0; m_scan[k] = 0;
      m_out[k] = 0; m_chg[k] = 0; m_ok[k] = 1;
      return;
    end
    nc = m_ch[k];
    if (!mode) begin
      if (sel < n) nc = sel;
      m_run[k] = 0;
    end else if (!m_scan[k]) begin
      m_run[k] = 0;
    end else if (!hold) begin
      m_run[k] = m_run[k] + 1;
      if (m_run[k] == dw) begin
        m_run[k] = 0;
        nc = (m_ch[k] + 1) % n;
      end
    end
    m_chg[k]  = (nc != m_ch[k]) ? 1 : 0;
    m_ch[k]   = nc;
    m_scan[k] = mode;
    m_out[k]  = int'(lanes[nc*8 +: 8]);
  endtask

  always @(posedge CLK) begin
    model_edge(0, 4, 3, RST, MODE, HOLD, int'(SEL), IN);
    model_edge(1, 3, 3, RST, mode3, 1'b0, int'(sel3), {8'h00, in3});
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (m_ok[0]) begin
      chk("m4_out", int'(out4), m_out[0]);
      chk("m4_ch",  int'(ch4),  m_ch[0]);
      chk("m4_chg", int'(chg4), m_chg[0]);
    end
    if (m_ok[1]) begin
      chk("m3_out", int'(out3), m_out[1]);
      chk("m3_ch",  int'(ch3),  m_ch[1]);
      chk("m3_chg", int'(chg3), m_chg[1]);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Hand-computed expectation checked against both DUT and model.
  task automatic lit4(input string nm, input int eo, input int ec, input int eg);
    @(negedge CLK);
    chk({nm, "_out"}, int'(out4), eo);
    chk({nm, "_ch"},  int'(ch4),  ec);
    chk({nm, "_chg"}, int'(chg4), eg);
    chk({nm, "_mdl_ch"},  m_ch[0],  ec);
    chk({nm, "_mdl_out"}, m_out[0], eo);
  endtask

  task automatic lit3(input string nm, input int eo, input int ec, input int eg);
    @(negedge CLK);
    chk({nm, "_out"}, int'(out3), eo);
    chk({nm, "_ch"},  int'(ch3),  ec);
    chk({nm, "_chg"}, int'(chg3), eg);
    chk({nm, "_mdl_ch"}, m_ch[1], ec);
  endtask

  initial begin
    int pulses;
    RST = 1'b1; SEL = 2'd0; MODE = 1'b0; HOLD = 1'b0;
    sel3 = 2'd0; mode3 = 1'b0;
    lane[0] = 8'h11; lane[1] = 8'h22; lane[2] = 8'h33; lane[3] = 8'h44;

    // Reset
    tick(); tick();
    lit4("reset", 8'h00, 0, 0);
    lit3("reset3", 8'h00, 0, 0);

    // Manual selects
    RST = 1'b0; SEL = 2'd2;
    tick(); lit4("sel2", 8'h33, 2, 1);
    tick(); lit4("sel2_again", 8'h33, 2, 0);
    lane[2] = 8'hA5;
    tick(); lit4("track", 8'hA5, 2, 0);
    SEL = 2'd0; lane[2] = 8'h33;
    tick(); lit4("sel0", 8'h11, 0, 1);

    // Scan rotation and wrap from CH=0
    MODE = 1'b1;
    pulses = 0;
    for (int i = 0; i < 13; i++) begin
      int c;
      c = (i / 3) % 4;
      tick();
      lit4("scan", 8'h11 * (c + 1), c, (i > 0 && i % 3 == 0) ? 1 : 0);
      if (i > 0) pulses += int'(chg4);
    end
    chk("scan_pulses", pulses, 4);

    // Reach CH=1 with counter=1, then hold mid-dwell
    tick(); tick(); tick(); tick();
    lit4("pre_hold", 8'h22, 1, 0);
    HOLD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); lit4("hold_mid", 8'h22, 1, 0);
    end
    HOLD = 1'b0;
    tick(); lit4("unhold1", 8'h22, 1, 0);
    tick(); lit4("unhold2", 8'h33, 2, 1);

    // Hold exactly at dwell expiry
    tick(); tick(); lit4("at_expiry", 8'h33, 2, 0);
    HOLD = 1'b1;
    tick(); tick(); lit4("hold_expiry", 8'h33, 2, 0);
    HOLD = 1'b0;
    tick(); lit4("deferred_adv", 8'h44, 3, 1);

    // Mode switch coinciding with dwell expiry
    tick(); tick(); lit4("ch3_expiry", 8'h44, 3, 0);
    MODE = 1'b0; SEL = 2'd1;
    tick(); lit4("to_manual", 8'h22, 1, 1);
    MODE = 1'b1;
    tick(); tick(); tick(); lit4("rescan_wait", 8'h22, 1, 0);
    tick(); lit4("rescan_adv", 8'h33, 2, 1);

    // Reset mid-scan at CH=2, counter=1
    tick(); lit4("pre_rst", 8'h33, 2, 0);
    RST = 1'b1;
    tick(); lit4("mid_rst", 8'h00, 0, 0);
    RST = 1'b0;
    tick(); lit4("rst_rel", 8'h11, 0, 0);
    tick(); tick(); lit4("rst_wait", 8'h11, 0, 0);
    tick(); lit4("rst_adv", 8'h22, 1, 1);

    // N=3 build: out-of-range select ignored
    sel3 = 2'd2;
    tick(); lit3("n3_sel2", 8'h33, 2, 1);
    sel3 = 2'd3;
    tick(); lit3("n3_sel3", 8'h33, 2, 0);
    tick(); lit3("n3_sel3b", 8'h33, 2, 0);
    sel3 = 2'd1;
    tick(); lit3("n3_sel1", 8'h22, 1, 1);

    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_n1_scan.md
Name: mux_n1_scan

Overview:
Parametrised, registered N:1 channel multiplexer; successor to the gate-level 2:1 mux.
- Selects one WIDTH-bit lane from N packed input lanes.
- Manual mode: channel comes from SEL.
- Scan mode: channel rotates round-robin, dwelling DWELL cycles per channel.
- Used wherever several data sources share one downstream consumer: displays, monitors, test outputs.

Parameters:
- N, 4, number of input channels (N >= 2).
- WIDTH, 8, bits per channel.
- DWELL, 3, cycles spent on each channel in scan mode (DWELL >= 1).
- SELW (localparam), $clog2(N), width of SEL and CH.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- SEL  input  SELW  manual channel select.
- MODE  input  1  0 = manual, 1 = scan.
- HOLD  input  1  scan mode only: freeze channel and dwell counter.
- IN  input  N*WIDTH  packed inputs; channel k = IN[k*WIDTH +: WIDTH].
- OUT  output  WIDTH  registered selected data.
- CH  output  SELW  registered current channel index.
- CH_CHG  output  1  one-cycle pulse, high in the cycle after CH changed.

Behaviour:
- Reset
  - One clock; RST sampled only on the rising edge of CLK.
  - RST=1 has priority over every other input.
  - Reset values: OUT=0, CH=0, CH_CHG=0, dwell counter=0, state MANUAL.
  - RST asserted mid-scan abandons the dwell immediately; the next non-reset edge starts from channel 0 with counter=0.
- Channel logic
  - next_ch is computed combinationally at each edge.
  - At that edge: CH<=next_ch, OUT<=IN[next_ch], CH_CHG<=(next_ch!=CH).
  - Latency: 1 cycle from SEL/IN to OUT. OUT tracks IN[CH] every cycle, even while the channel is held.
- State MANUAL (MODE=0)
  - next_ch = SEL if SEL < N; otherwise next_ch = CH. Out-of-range selects are ignored; this only applies when N is not a power of two.
  - The dwell counter is held at 0.
- State SCAN (MODE=1)
  - Dwell counter runs 0..DWELL-1.
  - HOLD=1: counter and channel frozen.
  - HOLD=0 and counter < DWELL-1: counter increments, next_ch=CH.
  - HOLD=0 and counter == DWELL-1: counter<=0, next_ch = (CH==N-1) ? 0 : CH+1 (wrap-around).
  - DWELL=1: channel advances every unheld cycle.
- Transitions
  - MANUAL->SCAN on the first edge with MODE=1.
    - Counter starts at 0 that edge; scan begins from the current CH.
    - The first advance occurs DWELL edges after entry (with HOLD=0).
  - SCAN->MANUAL on the first edge with MODE=0.
    - next_ch=SEL on that same edge (subject to the range check); counter cleared.
  - HOLD is ignored in MANUAL.
- Simultaneous events
  - RST with anything: reset wins.
  - MODE change with dwell expiry: the new mode's rule applies.
  - HOLD=1 at dwell expiry: no advance; the advance happens on the first edge with HOLD=0.
- CH_CHG
  - Never asserted in the cycle after reset.
  - Not asserted when SEL re-selects the current channel.

Test Plan:
- Reset, then manual selects (N=4, WIDTH=8, DWELL=3, IN lanes = 0x11,0x22,0x33,0x44).
  - RST=1 for 2 cycles -> OUT=0x00, CH=0, CH_CHG=0.
  - Release with MODE=0, SEL=2 -> next edge OUT=0x33, CH=2, CH_CHG=1 for one cycle.
- Manual data tracking and re-select.
  - SEL=2 held, lane 2 changed to 0xA5 -> OUT=0xA5 one edge later, CH_CHG stays 0.
  - SEL=0 -> OUT=0x11, CH_CHG pulses.
- Scan rotation and wrap.
  - Stimulus: CH=0, MODE=1, HOLD=0.
  - CH sequence per edge: 0,0,0,1,1,1,2,2,2,3,3,3,0.
  - OUT follows 0x11/0x22/0x33/0x44; CH_CHG pulses exactly 4 times over 12 edges.
- Hold mid-dwell and at expiry.
  - In scan on CH=1 with counter=1, HOLD=1 for 5 cycles -> CH stays 1.
  - After HOLD=0, CH=2 occurs 2 edges later.
  - HOLD asserted exactly at counter==2 -> advance deferred to the first unheld edge.
- Mode switch.
  - In scan at CH=3, MODE=0 with SEL=1 -> same edge CH=1, OUT=0x22.
  - MODE=1 again -> CH=2 after 3 edges.
  - N=3 build: SEL=3 in manual -> CH unchanged, CH_CHG=0.
- Reset mid-scan.
  - RST=1 at CH=2, counter=1 -> CH=0, OUT=0, CH_CHG=0.
  - With MODE=1 held, first advance to CH=1 occurs 3 edges after reset release.
